// File: rtl/row_deserializer_pkg.sv
// Shared types and helpers for the serial-to-row receive path.
package row_deserializer_pkg;

  typedef enum logic {
    COLLECT   = 1'b0,
    FULL_WAIT = 1'b1
  } state_t;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/row_deserializer_if.sv
// Sample-in / row-out handshake bundle for row_deserializer.
interface row_deserializer_if
  import row_deserializer_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int ROW_LEN   = 8
);
  localparam int CNT_W = clog2(ROW_LEN + 1);

  logic [REG_WIDTH-1:0]         idata;
  logic                         ivalid;
  logic                         iready;
  logic [REG_WIDTH*ROW_LEN-1:0] odata;
  logic                         ovalid;
  logic                         oready;
  logic [CNT_W-1:0]             ocount;

  modport slave  (input  idata, ivalid, oready,
                  output iready, odata, ovalid, ocount);
  modport master (output idata, ivalid, oready,
                  input  iready, odata, ovalid, ocount);
endinterface

// File: rtl/row_deserializer_hold.sv
// Parallel row holding register with valid/ready output handshake.
module row_hold_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_oready,
  output logic [W-1:0] o_data,
  output logic         o_valid
);
  logic [W-1:0] r_data;
  logic         r_valid;

  // A load wins over a concurrent drain so back-to-back rows have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_oready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/row_deserializer.sv
// Collects ROW_LEN serial samples into one row word, double-buffered against the holding stage.
module row_deserializer
  import row_deserializer_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int ROW_LEN   = 8
) (
  input  logic            clk,
  input  logic            rst,
  row_deserializer_if.slave s
);
  localparam int CNT_W = clog2(ROW_LEN + 1);
  localparam int IDX_W = clog2(ROW_LEN);

  logic [ROW_LEN-1:0][REG_WIDTH-1:0] r_buf;
  logic [ROW_LEN-1:0][REG_WIDTH-1:0] w_row;
  logic [CNT_W-1:0]                  r_cnt;
  state_t                            r_state;
  logic                              r_iready;
  logic                              w_ovalid;
  logic                              w_in_xfer;
  logic                              w_last;
  logic                              w_load;

  assign w_in_xfer = s.ivalid && r_iready;
  assign w_last    = (r_cnt == CNT_W'(ROW_LEN - 1));

  // In COLLECT the last sample bypasses the buffer straight into the hold stage.
  always_comb begin
    w_row  = r_buf;
    w_load = 1'b0;
    if (r_state == COLLECT) begin
      w_row[ROW_LEN-1] = s.idata;
      w_load = w_in_xfer && w_last && (!w_ovalid || s.oready);
    end else begin
      w_load = s.oready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf    <= '0;
      r_cnt    <= '0;
      r_state  <= COLLECT;
      r_iready <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_iready <= 1'b1;
          if (w_in_xfer) begin
            r_buf[r_cnt[IDX_W-1:0]] <= s.idata;
            if (!w_last) begin
              r_cnt <= r_cnt + 1'b1;
            end else if (w_load) begin
              r_cnt <= '0;
            end else begin
              r_cnt    <= CNT_W'(ROW_LEN);
              r_state  <= FULL_WAIT;
              r_iready <= 1'b0;
            end
          end
        end
        FULL_WAIT: begin
          if (s.oready) begin
            r_cnt    <= '0;
            r_state  <= COLLECT;
            r_iready <= 1'b1;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  row_hold_reg #(.W(REG_WIDTH * ROW_LEN)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_row),
    .i_oready(s.oready),
    .o_data  (s.odata),
    .o_valid (w_ovalid)
  );

  assign s.ovalid = w_ovalid;
  assign s.iready = r_iready;
  assign s.ocount = r_cnt;
endmodule

// File: tb/tb_row_deserializer.sv
// Randomized scoreboard bench for row_deserializer against a sample-queue reference model.
module tb_row_deserializer;
  localparam int W = 8;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_deserializer_if #(.REG_WIDTH(W), .ROW_LEN(L)) bus ();
  row_deserializer #(.REG_WIDTH(W), .ROW_LEN(L)) dut (.clk(clk), .rst(rst), .s(bus.slave));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit skip = 1'b1;

  // Reference model: completed rows awaiting delivery plus the row being gathered.
  logic [W*L-1:0] expq[$];
  logic [W*L-1:0] cur = '0;
  logic [W*L-1:0] last_row = '0;
  int pcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: check outputs against the model, then advance the model by this cycle's transfers.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      pcnt = 0;
      cur = '0;
      last_row = '0;
    end else if (!skip) begin
      chk("ovalid", 64'(bus.ovalid), 64'(expq.size() > 0));
      chk("iready", 64'(bus.iready), 64'(expq.size() < 2));
      chk("ocount", 64'(bus.ocount), 64'((expq.size() == 2) ? L : pcnt));
      if (expq.size() > 0) chk("odata_row", bus.odata, expq[0]);
      else                 chk("odata_idle", bus.odata, last_row);
      if (bus.ovalid && bus.oready && expq.size() > 0) last_row = expq.pop_front();
      if (bus.ivalid && bus.iready) begin
        cur[pcnt*W +: W] = bus.idata;
        pcnt++;
        if (pcnt == L) begin
          expq.push_back(cur);
          pcnt = 0;
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] d);
    int t;
    t = 0;
    bus.idata  = d;
    bus.ivalid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.iready) break;
      t++;
      if (t > 200) begin
        chk("push_timeout", 64'(t), 64'(0));
        bus.ivalid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.ivalid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.ivalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    skip = 1'b1;
    rst  = 1'b1;
    bus.ivalid = 1'b0;
    #1;
    chk("rst_ovalid", 64'(bus.ovalid), 64'(0));
    chk("rst_ocount", 64'(bus.ocount), 64'(0));
    chk("rst_iready", 64'(bus.iready), 64'(0));
    chk("rst_odata", bus.odata, 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    skip = 1'b0;
  endtask

  initial begin
    int c0;
    int t;
    bit acc;
    rst = 1'b1;
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.oready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Basic row
    bus.oready = 1'b1;
    for (int i = 0; i < 8; i++) push(W'(i));
    idle(3);

    // Back-to-back rows at full rate
    c0 = cyc;
    for (int i = 0; i < 24; i++) push(W'(i));
    chk("b2b_cycles", 64'(cyc - c0), 64'(24));
    idle(3);

    // Backpressure, ignored sample while not ready, single oready pulse
    bus.oready = 1'b0;
    for (int i = 0; i < 16; i++) push(W'(i));
    bus.idata  = 8'hFF;
    bus.ivalid = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    @(posedge clk); #1;
    bus.oready = 1'b0;
    idle(3);
    bus.oready = 1'b1;
    idle(3);

    // Bubbles between samples
    for (int i = 0; i < 8; i++) begin
      push(W'(8'hA0 + i));
      idle(1);
    end
    idle(2);

    // Reset with a held row and a partial row
    bus.oready = 1'b0;
    for (int i = 0; i < 8; i++) push(W'(8'h50 + i));
    for (int i = 0; i < 5; i++) push(W'(8'h60 + i));
    do_reset();
    bus.oready = 1'b1;
    for (int i = 0; i < 8; i++) push(W'(8'h10 + i));
    idle(3);

    // Last sample accepted in the same cycle the held row drains
    bus.oready = 1'b0;
    for (int i = 0; i < 8; i++) push(W'(8'hB0 + i));
    for (int i = 0; i < 7; i++) push(W'(8'hC0 + i));
    bus.oready = 1'b1;
    push(8'hC7);
    idle(3);

    // Randomized traffic and backpressure
    bus.ivalid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      acc = bus.ivalid && bus.iready;
      @(posedge clk); #1;
      if (acc || !bus.ivalid) begin
        bus.ivalid = ($urandom_range(3) != 0);
        bus.idata  = W'($urandom);
      end
      bus.oready = ($urandom_range(2) != 0);
    end

    // Drain
    bus.ivalid = 1'b0;
    bus.oready = 1'b1;
    t = 0;
    while (expq.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 64'(expq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/row_deserializer.md
Name: row_deserializer

Overview:
- Receiver end of the serial pixel path in the JPEG pipeline.
- Collects row_len consecutive samples, delivered one per clock under a valid/ready handshake, into one parallel row word.
- Hands each complete row to the row-parallel stage (DCT input) through a registered output holding stage with its own valid/ready handshake.
- Provides decoupling: the next row can be collected while the previous row waits to be consumed.

Parameters:
- reg_width, 8, bits per sample
- row_len, 8, samples per row (>=2)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- idata  input  reg_width  serial sample in
- ivalid  input  1  idata valid
- iready  output  1  block can accept a sample this cycle
- odata  output  reg_width*row_len  assembled row; sample 0 in bits [reg_width-1:0], sample k in bits [(k+1)*reg_width-1 : k*reg_width]
- ovalid  output  1  odata holds a complete row
- oready  input  1  downstream accepts row this cycle
- ocount  output  clog2(row_len+1)  samples currently held in collect buffer (debug/status)

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: iready=0 while rst high and 1 on the first cycle after release; ovalid=0, odata=0, ocount=0; collect buffer cleared; state=COLLECT.
- Input transfer occurs when ivalid && iready at the rising edge. idata is ignored whenever iready=0.
- Output transfer occurs when ovalid && oready. odata is stable while ovalid=1 and oready=0.
- All outputs are registered. There is no combinational path from oready to iready, or from ivalid to ovalid.
- State COLLECT:
  - iready=1.
  - Each input transfer writes idata to slot cnt, then cnt++.
  - On transfer of slot row_len-1:
    - Holding register free, or freeing this cycle (ovalid=0 or oready=1): copy the full row into the holding register, ovalid=1 next cycle, cnt=0, stay in COLLECT.
    - Otherwise: go to FULL_WAIT, cnt=row_len.
- State FULL_WAIT:
  - iready=0.
  - On an output transfer: the holding register loads the collect buffer, ovalid stays 1, cnt=0, return to COLLECT (iready=1 next cycle).
- Output transfer with no new row completing the same cycle: ovalid=0 next cycle, and odata keeps its last value.
- Simultaneous last-sample input and output transfer: the holding register takes the new row, and ovalid stays 1 with no bubble.
- Latency: the row appears on odata the cycle after its last sample is accepted.
- Throughput: with oready tied to 1, one sample per clock is sustained indefinitely.
- ocount = cnt. It wraps row_len-1 -> 0 and never exceeds row_len.
- Reset mid-row discards the partial row and any held row. The first sample after release becomes slot 0.
- No width growth or arithmetic on data: samples are copied bit-exact.

Decomposition:
- Shared header/package:
  - state encodings (COLLECT=0, FULL_WAIT=1)
  - clog2 constant function, reused for counter widths across pipeline blocks
- Natural sub-module: row_hold_reg, the parallel holding register with ovalid/oready handshake and load/clear control.
- The collect buffer and state machine stay in the top module.

Test Plan:
- Basic row: reset, oready=1, ivalid=1 with idata 0x00..0x07 over 8 cycles -> ovalid=1 on the 9th cycle, odata=0x0706050403020100, ovalid=0 the following cycle.
- Back-to-back rows: 24 continuous samples 0x00..0x17, oready=1 -> iready never drops; three rows on ovalid exactly 8 cycles apart: 0x0706050403020100, 0x0F0E0D0C0B0A0908, 0x1716151413121110.
- Backpressure: oready=0, feed 16 samples -> first row held stable; after the 16th sample iready=0 and ocount=8. Extra idata=0xFF offered while iready=0 is ignored. Pulse oready for one cycle -> second row 0x0F0E..08 is presented and iready=1 on the next cycle.
- Bubbles: ivalid toggles 1/0 over samples 0xA0..0xA7 -> ocount steps only on transfers; row 0xA7A6A5A4A3A2A1A0 appears the cycle after the 8th transfer.
- Reset mid-operation: assert rst after 5 samples while a row is held -> ovalid=0, ocount=0 immediately. After release, samples 0x10..0x17 -> odata=0x1716151413121110.
- Simultaneous events: holding register full with oready=1 in the same cycle as the 8th sample is accepted -> ovalid stays 1 continuously and the new row replaces the old on the next edge.
